// File: rtl/agc_gain16_if.sv
// Sample and gain-code bundle between the log multiplier and the AGC stage.
// Latency: none (wires only).
// Backpressure: none; the AGC accepts one sample per clock unconditionally.
//
// Signals: dix/diy/iv carry the I/Q sample with its valid flag. gain/gv carry
// the gain code with its update strobe. mag/st expose the magnitude and state.
// hold (freeze) exists only when AGC_HOLD_EN is defined.
interface agc_gain16_if;
  logic signed [15:0] dix;
  logic signed [15:0] diy;
  logic               iv;
  logic        [15:0] gain;
  logic               gv;
  logic        [15:0] mag;
  logic        [1:0]  st;
`ifdef AGC_HOLD_EN
  logic               hold;
`endif

  // master: the sample source (multiplier side / testbench)
  modport master (
    output dix, diy, iv,
`ifdef AGC_HOLD_EN
    output hold,
`endif
    input  gain, gv, mag, st
  );

  // slave: the AGC stage itself
  modport slave (
    input  dix, diy, iv,
`ifdef AGC_HOLD_EN
    input  hold,
`endif
    output gain, gv, mag, st
  );
endinterface

// File: rtl/agc_gain16.sv
// AGC loop stage: |I|,|Q| -> magnitude estimate -> attack/hang/decay gain code.
// Latency: sample with iv at edge n updates gain/mag/st at edge n+3 (gv for 1 clk).
// Backpressure: none; one sample per clock, gaps in iv leave all state untouched.
//
// Ports: clk (rising edge), rst (synchronous, active high),
//   io.dix/io.diy/io.iv  signed I/Q sample with valid,
//   io.gain/io.gv        gain code ([15:12] exp, [11:0] mantissa) and update strobe,
//   io.mag/io.st         last processed magnitude, state (0 DECAY, 1 ATTACK, 2 HANG),
//   io.hold              freeze gain/hang/state; only when AGC_HOLD_EN is defined.
module agc_gain16 #(
  parameter logic [15:0] TARGET      = 16'h4000,
  parameter logic [15:0] ATTACK_STEP = 16'd256,
  parameter logic [15:0] DECAY_STEP  = 16'd1,
  parameter logic [15:0] HANG        = 16'd4,
  parameter logic [15:0] GINIT       = 16'h8000,
  parameter logic [15:0] GMAX        = 16'hF800
) (
  input  logic          clk,
  input  logic          rst,
  agc_gain16_if.slave   io
);

  typedef enum logic [1:0] {
    ST_DECAY  = 2'd0,
    ST_ATTACK = 2'd1,
    ST_HANG   = 2'd2
  } st_t;

  // ---------------------------------------------------------------------------
  // Valid pipeline (reset flushes everything in flight)
  // ---------------------------------------------------------------------------
  logic r_v0, r_v1, r_v2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v0 <= 1'b0;
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      r_v0 <= io.iv;
      r_v1 <= r_v0;
      r_v2 <= r_v1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 0: input capture. Stage 1: absolute values. Stage 2: magnitude.
  // Data registers carry no reset; only the valid bits qualify them.
  // ---------------------------------------------------------------------------
  logic signed [15:0] r_dix, r_diy;
  logic        [15:0] r_ax, r_ay;
  logic        [15:0] r_mag2;

  logic [15:0] w_ax, w_ay;
  logic [15:0] w_max, w_min, w_half;
  logic [16:0] w_sum;
  logic [15:0] w_mag;

  // Two's-complement negate as unsigned: -32768 maps to 16'h8000 = 32768,
  // which is exactly representable, so no wrap.
  assign w_ax   = r_dix[15] ? (~r_dix + 16'd1) : r_dix;
  assign w_ay   = r_diy[15] ? (~r_diy + 16'd1) : r_diy;

  assign w_max  = (r_ax >= r_ay) ? r_ax : r_ay;
  assign w_min  = (r_ax >= r_ay) ? r_ay : r_ax;
  assign w_half = w_min >> 1;
  assign w_sum  = {1'b0, w_max} + {1'b0, w_half};
  assign w_mag  = w_sum[16] ? 16'hFFFF : w_sum[15:0];

  always_ff @(posedge clk) begin
    r_dix  <= io.dix;
    r_diy  <= io.diy;
    r_ax   <= w_ax;
    r_ay   <= w_ay;
    r_mag2 <= w_mag;
  end

  // ---------------------------------------------------------------------------
  // Stage 3: attack/hang/decay decision and gain update
  // ---------------------------------------------------------------------------
  logic        w_hold;
`ifdef AGC_HOLD_EN
  assign w_hold = io.hold;
`else
  assign w_hold = 1'b0;
`endif

  st_t         r_st,   w_st_nxt;
  logic [15:0] r_gain, w_gain_nxt;
  logic [15:0] r_hang, w_hang_nxt;
  logic [15:0] r_mag;
  logic        r_gv;

  // 17-bit arithmetic: bit 16 of the difference is the borrow (floor at 0);
  // the sum is compared in 17 bits so it can never wrap past GMAX.
  logic [16:0] w_sub, w_add;
  assign w_sub = {1'b0, r_gain} - {1'b0, ATTACK_STEP};
  assign w_add = {1'b0, r_gain} + {1'b0, DECAY_STEP};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st   <= ST_DECAY;
      r_gain <= GINIT;
      r_hang <= 16'd0;
      r_mag  <= 16'd0;
      r_gv   <= 1'b0;
    end else begin
      r_st   <= w_st_nxt;
      r_gain <= w_gain_nxt;
      r_hang <= w_hang_nxt;
      r_gv   <= r_v2;
      if (r_v2) begin
        r_mag <= r_mag2;
      end
    end
  end

  always_comb begin
    w_st_nxt   = r_st;
    w_gain_nxt = r_gain;
    w_hang_nxt = r_hang;
    if (r_v2 && !w_hold) begin
      if (r_mag2 > TARGET) begin
        w_gain_nxt = w_sub[16] ? 16'd0 : w_sub[15:0];
        w_hang_nxt = HANG;
        w_st_nxt   = ST_ATTACK;
      end else if (r_hang != 16'd0) begin
        w_hang_nxt = r_hang - 16'd1;
        w_st_nxt   = ST_HANG;
      end else begin
        // Also pulls an over-range GINIT down to GMAX on the first decay.
        w_gain_nxt = (w_add > {1'b0, GMAX}) ? GMAX : w_add[15:0];
        w_st_nxt   = ST_DECAY;
      end
    end
  end

  assign io.gain = r_gain;
  assign io.gv   = r_gv;
  assign io.mag  = r_mag;
  assign io.st   = r_st;

endmodule

// File: tb/tb_agc_gain16.sv
// Testbench for agc_gain16: directed steps plus random samples against a
// sample-level reference model.
module tb_agc_gain16;
  localparam int TARGET = 16384;
  localparam int ATK    = 256;
  localparam int DEC    = 1;
  localparam int HANGN  = 4;
  localparam int GINIT  = 32768;
  localparam int GMAX   = 63488;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  agc_gain16_if io ();
  agc_gain16_if io2 ();

  agc_gain16 u_dut (.clk(clk), .rst(rst), .io(io));
  agc_gain16 #(.GINIT(16'hF7FF)) u_dut2 (.clk(clk), .rst(rst), .io(io2));

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct { int due; int dx; int dy; } smp_t;
  smp_t q[$];

  int m_gain = GINIT;
  int m_hang = 0;
  int m_st   = 0;
  int m_mag  = 0;
  bit tb_hold = 1'b0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: magnitude from plain integer arithmetic, then the rule table.
  task automatic model_apply(input int dx, input int dy, input bit h);
    int ax, ay, mx, mn, mg;
    ax = (dx < 0) ? -dx : dx;
    ay = (dy < 0) ? -dy : dy;
    mx = (ax > ay) ? ax : ay;
    mn = (ax > ay) ? ay : ax;
    mg = mx + mn / 2;
    if (mg > 65535) mg = 65535;
    m_mag = mg;
    if (!h) begin
      if (mg > TARGET) begin
        m_gain = (m_gain - ATK < 0) ? 0 : m_gain - ATK;
        m_hang = HANGN;
        m_st   = 1;
      end else if (m_hang != 0) begin
        m_hang = m_hang - 1;
        m_st   = 2;
      end else begin
        m_gain = (m_gain + DEC > GMAX) ? GMAX : m_gain + DEC;
        m_st   = 0;
      end
    end
  endtask

  // One clock: drive inputs, take the edge, then compare everything #1 later.
  task automatic step(input int dx, input int dy, input bit v, input bit r, input bit h);
    smp_t s;
    bit   exp_gv;
    io.dix  = 16'(dx);
    io.diy  = 16'(dy);
    io.iv   = v;
    rst     = r;
    tb_hold = h;
`ifdef AGC_HOLD_EN
    io.hold = h;
`endif
    @(posedge clk);
    cyc++;
    if (r) begin
      q.delete();
      m_gain = GINIT; m_hang = 0; m_st = 0; m_mag = 0;
    end else if (v) begin
      s.due = cyc + 3; s.dx = dx; s.dy = dy;
      q.push_back(s);
    end
    #1;
    exp_gv = 1'b0;
    if (!r && q.size() > 0 && q[0].due == cyc) begin
      s = q.pop_front();
      model_apply(s.dx, s.dy, h);
      exp_gv = 1'b1;
    end
    chk("gv",   {15'd0, io.gv}, {15'd0, exp_gv});
    chk("gain", io.gain,        16'(m_gain));
    chk("mag",  io.mag,         16'(m_mag));
    chk("st",   {14'd0, io.st}, 16'(m_st));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    io.dix = '0; io.diy = '0; io.iv = 1'b0;
    io2.dix = '0; io2.diy = '0; io2.iv = 1'b0;
`ifdef AGC_HOLD_EN
    io.hold = 1'b0; io2.hold = 1'b0;
`endif

    // Reset and idle: no gv, reset values hold
    step(0, 0, 1'b0, 1'b1, 1'b0);
    chk("rst_gain", io.gain, 16'h8000);
    chk("rst_mag",  io.mag,  16'h0000);
    chk("rst_st",   {14'd0, io.st}, 16'd0);
    chk("rst_gv",   {15'd0, io.gv}, 16'd0);
    idle(10);

    // Single attack sample
    step(32767, 0, 1'b1, 1'b0, 1'b0);
    idle(2);
    step(0, 0, 1'b0, 1'b0, 1'b0);
    chk("atk_mag",  io.mag,  16'h7FFF);
    chk("atk_gain", io.gain, 16'h7F00);
    chk("atk_st",   {14'd0, io.st}, 16'd1);
    chk("atk_gv",   {15'd0, io.gv}, 16'd1);
    step(0, 0, 1'b0, 1'b0, 1'b0);
    chk("atk_gv_end", {15'd0, io.gv}, 16'd0);

    // Hang for 4 samples, then decay
    for (int i = 0; i < 5; i++) step(16, -16, 1'b1, 1'b0, 1'b0);
    idle(3);
    chk("decay_gain", io.gain, 16'h7F01);
    chk("decay_st",   {14'd0, io.st}, 16'd0);
    chk("decay_mag",  io.mag,  16'd24);

    // Magnitude corner: full-scale negative on both rails, then exactly TARGET
    step(-32768, -32768, 1'b1, 1'b0, 1'b0);
    idle(3);
    chk("corner_mag", io.mag, 16'hC000);
    chk("corner_st",  {14'd0, io.st}, 16'd1);
    step(16384, 0, 1'b1, 1'b0, 1'b0);
    idle(3);
    chk("target_mag", io.mag, 16'h4000);
    chk("target_st",  {14'd0, io.st}, 16'd2);
    chk("target_gain", io.gain, 16'h7E01);

    // Floor saturation: 200 back-to-back attacks from reset
    step(0, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 200; i++) step(32767, 0, 1'b1, 1'b0, 1'b0);
    idle(4);
    chk("floor_gain", io.gain, 16'h0000);

    // Reset mid-flight flushes the sample
    step(32767, 0, 1'b1, 1'b0, 1'b0);
    step(0, 0, 1'b0, 1'b1, 1'b0);
    step(0, 0, 1'b0, 1'b0, 1'b0);
    chk("flush_gv",   {15'd0, io.gv}, 16'd0);
    chk("flush_gain", io.gain, 16'h8000);
    idle(3);

    // Random samples: mostly small, occasionally large, with iv gaps
    step(0, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 400; i++) begin
      logic [15:0] rx, ry;
      int dx, dy;
      rx = 16'($urandom);
      ry = 16'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        dx = int'($signed(rx));
        dy = int'($signed(ry));
      end else begin
        dx = int'($signed(rx)) % 4096;
        dy = int'($signed(ry)) % 4096;
      end
      step(dx, dy, ($urandom_range(0, 3) != 0), 1'b0, 1'b0);
    end
    idle(4);

`ifdef AGC_HOLD_EN
    // Hold: attack sample reaching stage 3 with hold=1 leaves gain alone
    step(32767, 0, 1'b1, 1'b0, 1'b1);
    step(0, 0, 1'b0, 1'b0, 1'b1);
    step(0, 0, 1'b0, 1'b0, 1'b1);
    step(0, 0, 1'b0, 1'b0, 1'b1);
    chk("hold_mag", io.mag, 16'h7FFF);
    chk("hold_gv",  {15'd0, io.gv}, 16'd1);
    idle(2);
`endif

    // Ceiling saturation on the GINIT=F7FF instance
    step(0, 0, 1'b0, 1'b1, 1'b0);
    chk("g2_rst", io2.gain, 16'hF7FF);
    io2.dix = '0; io2.diy = '0; io2.iv = 1'b1;
    step(0, 0, 1'b0, 1'b0, 1'b0);
    idle(2);
    io2.iv = 1'b1;
    step(0, 0, 1'b0, 1'b0, 1'b0);
    chk("g2_first",    io2.gain, 16'hF800);
    chk("g2_first_gv", {15'd0, io2.gv}, 16'd1);
    io2.iv = 1'b0;
    idle(4);
    chk("g2_ceiling", io2.gain, 16'hF800);
    chk("g2_st",      {14'd0, io2.st}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/agc_gain16.md
# agc_gain16

Automatic gain control loop stage for the 16-bit I/Q path. It consumes the scaled 16-bit output of the logarithmic multiplier and estimates the instantaneous magnitude of each sample. It runs an attack/hang/decay state machine and produces the 16-bit gain code that feeds back into the multiplier's `gain` input. Fully pipelined; it accepts one sample per clock.

## Interface
- `TARGET`, 16'h4000: magnitude threshold. Magnitude above it triggers attack.
- `ATTACK_STEP`, 256: gain-code decrement per over-target sample.
- `DECAY_STEP`, 1: gain-code increment per decay sample.
- `HANG`, 4: number of valid samples to hold gain after an attack (0–65535).
- `GINIT`, 16'h8000: gain code after reset.
- `GMAX`, 16'hF800: upper gain-code limit.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `dix`  in  16  signed I sample (multiplier `dox`).
- `diy`  in  16  signed Q sample (multiplier `doy`).
- `iv`  in  1  input valid (multiplier `ov`).
- `gain`  out  16  gain code: [15:12] exponent, [11:0] mantissa (0.5–1). Monotonic in linear gain.
- `gv`  out  1  one-cycle strobe when `gain` has been updated.
- `mag`  out  16  magnitude of the last sample processed.
- `st`  out  2  state: 0 DECAY, 1 ATTACK, 2 HANG.
- `hold`  in  1  freeze gain (present only with `AGC_HOLD_EN`).

## Operation
- Stage 1 takes absolute values into 16-bit unsigned registers: ax = |dix|, ay = |diy|. |−32768| = 32768, so no wrap occurs.
- Stage 2 computes mag = max(ax,ay) + (min(ax,ay) >> 1). The sum is 17 bits and saturates to 16'hFFFF.
- Stage 3 runs the decision and gain update; each valid sample follows the first matching rule:
  - mag > TARGET:
    - gain ← max(gain − ATTACK_STEP, 0).
    - hang counter ← HANG.
    - st ← ATTACK.
  - Otherwise, if the hang counter ≠ 0:
    - hang counter decrements.
    - gain is unchanged.
    - st ← HANG.
  - Otherwise:
    - gain ← min(gain + DECAY_STEP, GMAX).
    - st ← DECAY.
- mag == TARGET is not an attack.
- With HANG = 0, the sample after an attack decays immediately.
- All gain arithmetic is 17-bit with saturation. The gain code never wraps through 0 or above GMAX.
- A GINIT above GMAX is clamped to GMAX on the first decay.
- `gv` pulses for every valid sample reaching stage 3, including hang samples where gain is unchanged.
- The hang counter is 16 bits and counts valid samples, not clocks.

## Timing
- Reset values:
  - gain = GINIT.
  - gv = 0, mag = 0, st = DECAY (0).
  - hang counter = 0.
  - All pipeline valid bits clear.
- Latency: a sample with iv=1 at edge n updates gain, mag and st at edge n+3; gv is high for the clock after edge n+3.
- Back-to-back iv on every clock is supported. Each sample sees the gain-code/hang state left by the previous sample.
- Gaps in iv leave state untouched; no decay occurs without samples.
- Reset mid-operation flushes all in-flight samples: no gv follows, and state returns to reset values on the same edge.

## Configuration
- `AGC_HOLD_EN` defined:
  - The `hold` port exists.
  - When hold=1 at stage 3, gain, hang counter and st are frozen.
  - mag still updates and gv still pulses.
- `AGC_HOLD_EN` undefined:
  - The port is absent.
  - Behaviour is identical to hold=0.

## Test plan
All tests use default parameters.
- Reset: assert rst for 1 clk → gain=16'h8000, gv=0, mag=0, st=0; no gv for 10 idle clocks.
- Attack: one sample dix=16'h7FFF, diy=0 → 3 clks later mag=16'h7FFF, gain=16'h7F00, st=1, gv high for exactly 1 clk.
- Hang/decay: after the attack, send 5 samples dix=16, diy=−16 (mag=24) → 4 gv pulses with gain=16'h7F00, st=2; 5th gives gain=16'h7F01, st=0.
- Magnitude corner: dix=diy=−32768 → mag=16'hC000, attack taken. Then dix=16'h4000, diy=0 → mag=16'h4000, no attack.
- Saturation:
  - 200 back-to-back dix=16'h7FFF samples from reset → gain reaches 0 and stays 0.
  - Decay with GINIT=16'hF7FF → gain stops at 16'hF800.
- Reset mid-flight: iv=1 at edge n, rst=1 at edge n+1 → no gv at n+3, gain=16'h8000. With `AGC_HOLD_EN` and hold=1, an attack sample leaves gain unchanged but mag updates.
